// File: rtl/keypad_scanner_if.sv
// Signal bundle between a 4x4 matrix keypad scanner and its surroundings.
// slave = scanner side, master = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [1:0] state_dbg;

  // key_valid is a one-clk strobe with no back-pressure (no ready); key_code
  // is already stable when it rises and holds until the next accepted press.
  modport slave (
    input  col,
    output row,
    output key_code,
    output key_valid,
    output key_down,
    output state_dbg
  );

  modport master (
    output col,
    input  row,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  state_dbg
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotates one low row per scan tick and
// debounces press and release over DEBOUNCE_CNT consecutive tick samples.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.slave  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    col_s1;
  logic [3:0]    col_s2;
  logic [3:0]    cand_pat;
  logic [3:0]    cand_code;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tick;
  logic          one_low;
  logic          all_high;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;

  assign kp.state_dbg = state;
  assign tick         = (div == DIV_LAST);
  assign all_high     = &col_s2;
  assign cnt_nxt      = cnt + CW'(1);

  always_comb begin
    col_idx = 2'd0;
    one_low = 1'b0;
    case (col_s2)
      4'b1110: begin col_idx = 2'd0; one_low = 1'b1; end
      4'b1101: begin col_idx = 2'd1; one_low = 1'b1; end
      4'b1011: begin col_idx = 2'd2; one_low = 1'b1; end
      4'b0111: begin col_idx = 2'd3; one_low = 1'b1; end
      default: begin col_idx = 2'd0; one_low = 1'b0; end
    endcase
  end

  always_comb begin
    row_idx = 2'd0;
    case (kp.row)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // col comes straight off the keypad pins, asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= kp.col;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= SCAN;
      kp.row       <= 4'b1110;
      cnt          <= '0;
      cand_pat     <= 4'b1111;
      cand_code    <= 4'h0;
      kp.key_code  <= 4'h0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              cand_pat  <= col_s2;
              cand_code <= {row_idx, col_idx};
              if (DEBOUNCE_CNT == 1) begin
                kp.key_code  <= {row_idx, col_idx};
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
                cnt          <= '0;
                state        <= PRESSED;
              end else begin
                cnt   <= CW'(1);
                state <= DEBOUNCE;
              end
            end else begin
              kp.row <= {kp.row[2:0], kp.row[3]};
            end
          end
          DEBOUNCE: begin
            if (col_s2 == cand_pat) begin
              if (cnt_nxt == DEB_MAX) begin
                kp.key_code  <= cand_code;
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
                cnt          <= '0;
                state        <= PRESSED;
              end else begin
                cnt <= cnt_nxt;
              end
            end else begin
              cnt    <= '0;
              kp.row <= {kp.row[2:0], kp.row[3]};
              state  <= SCAN;
            end
          end
          PRESSED: begin
            // Extra keys on the held row keep the press alive but are never reported.
            if (all_high) begin
              if (DEBOUNCE_CNT == 1) begin
                kp.key_down <= 1'b0;
                cnt         <= '0;
                kp.row      <= {kp.row[2:0], kp.row[3]};
                state       <= SCAN;
              end else begin
                cnt   <= CW'(1);
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (all_high) begin
              if (cnt_nxt == DEB_MAX) begin
                kp.key_down <= 1'b0;
                cnt         <= '0;
                kp.row      <= {kp.row[2:0], kp.row[3]};
                state       <= SCAN;
              end else begin
                cnt <= cnt_nxt;
              end
            end else begin
              cnt   <= '0;
              state <= PRESSED;
            end
          end
          default: begin
            cnt   <= '0;
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (min 2).
REQ-002 Parameter DEBOUNCE_CNT, default 4, consecutive identical tick samples needed to accept a press or a release (min 1).
REQ-003 clk  input  1  system clock; only clock in the block.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 col  input  4  keypad column lines, active-low (pulled up), asynchronous to clk.
REQ-006 row  output 4  keypad row drive, active-low, at most one bit low.
REQ-007 key_code  output 4  last accepted key, {row_idx[1:0], col_idx[1:0]}, where row_idx selects row[row_idx] and col_idx selects col[col_idx].
REQ-008 key_valid  output 1  one-clk pulse when a new press is accepted.
REQ-009 key_down  output 1  level, high while an accepted key is held.

Function
REQ-010 col SHALL pass through a 2-flop synchronizer before use; the synchronizer resets to 4'b1111.
REQ-011 Divider SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL assert for one clk when divider = SCAN_DIV-1.
REQ-012 All sampling, counting and state changes SHALL occur only on tick cycles; between ticks, row, state and counters hold.
REQ-013 Sample SHALL mean the synchronized col, evaluated on the tick against the currently driven row.
REQ-014 Row advance SHALL rotate the low bit: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 States: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-016 SCAN, sample exactly one col bit low: latch candidate code, hold row, cnt = 1, go DEBOUNCE; if DEBOUNCE_CNT = 1, go directly to PRESSED per REQ-018.
REQ-017 SCAN, sample all high or two or more bits low: advance row, stay SCAN.
REQ-018 DEBOUNCE, sample equals candidate: cnt++; when cnt reaches DEBOUNCE_CNT, set key_code = candidate, pulse key_valid, set key_down = 1, go PRESSED.
REQ-019 DEBOUNCE, sample differs from candidate: cnt = 0, advance row, go SCAN, no output change.
REQ-020 PRESSED: row held; any sample with a bit low keeps PRESSED, including extra keys, which are ignored; sample all high gives cnt = 1, go RELEASE.
REQ-021 RELEASE, all high: cnt++; at DEBOUNCE_CNT, key_down = 0, advance row, go SCAN; key_code retains its value.
REQ-022 RELEASE, any bit low: cnt = 0, return to PRESSED; no new key_valid.
REQ-023 key_valid SHALL never assert twice for one continuous accepted press.
REQ-024 Latency from a stable col change to the first sample is at most 2 clk of sync delay plus SCAN_DIV clk.

Reset
REQ-025 On rst low, immediately and asynchronously: row = 4'b1110, state = SCAN, divider = 0, cnt = 0, key_code = 4'h0, key_valid = 0, key_down = 0, sync = 4'b1111.
REQ-026 Reset mid-press SHALL abort it; after release of reset the block rescans from row 1110, and a still-held key is reaccepted with a new key_valid.

Verification (SCAN_DIV = 4, DEBOUNCE_CNT = 3)
REQ-027 Assert rst = 0 mid-cycle -> row = 1110, key_valid = 0, key_down = 0, key_code = 0, with no clk edge needed.
REQ-028 col = 1111 throughout -> row steps 1110, 1101, 1011, 0111, 1110, each held 4 clk; key_valid never asserts.
REQ-029 Hold col = 1101 (col_idx 1) while row = 1011 (row_idx 2) -> after 3 ticks: a single key_valid pulse, key_code = 4'h9, key_down = 1, row held at 1011.
REQ-030 col low for 1 tick, then 1111 -> no key_valid; row resumes advancing from the next row.
REQ-031 col = 1100 (two keys, same row) -> ignored; scanning continues; no key_valid.
REQ-032 From PRESSED: col = 1111 for 1 tick, then 1101 again -> key_down stays 1, no key_valid; then col = 1111 for 3 ticks -> key_down = 0, row advances to 0111.
